pcie_pio_rx_engine: RTL and testbench

Receive-side programmed-I/O engine between the PCIe core's 64-bit TRN receive interface and the DMA application's control-register file. It parses 3DW/4DW single-DW memory read and write TLPs that hit BAR0. Writes become one-cycle register write strobes. Reads become a held completion request for the TX completion engine. Every other TLP is consumed, discarded and counted.

---
 rtl/pcie_pio_rx_engine_if.sv | 24 ++
 rtl/pcie_pio_rx_engine.sv | 199 +++++++++++++++++++
 tb/tb_pcie_pio_rx_engine.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_pio_rx_engine_if.sv
// TRN receive-side bus between the PCIe core (master) and the PIO receive engine (slave).
interface pcie_pio_rx_engine_if;
  logic        trn_lnk_up_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic [63:0] trn_rd;
  logic        trn_rrem_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n;

  modport master (
    output trn_lnk_up_n, trn_rsof_n, trn_reof_n, trn_rd, trn_rrem_n,
           trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
    input  trn_rdst_rdy_n
  );

  modport slave (
    input  trn_lnk_up_n, trn_rsof_n, trn_reof_n, trn_rd, trn_rrem_n,
           trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rbar_hit_n,
    output trn_rdst_rdy_n
  );
endinterface

// File: rtl/pcie_pio_rx_engine.sv
// PIO receive engine: turns single-DW BAR0 MRd/MWr TLPs into register write strobes
// and held completion requests; every other TLP is swallowed and counted.
module pcie_pio_rx_engine #(
  parameter int ADDR_W = 10
) (
  input  logic                trn_clk,
  input  logic                trn_reset_n,
  pcie_pio_rx_engine_if.slave rx,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [31:0]         wr_data,
  output logic [3:0]          wr_be,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [15:0]         rd_req_id,
  output logic [7:0]          rd_tag,
  output logic [2:0]          rd_tc,
  output logic [1:0]          rd_attr,
  output logic [6:0]          rd_lower_addr,
  output logic [3:0]          rd_be,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [2:0] {IDLE, HDR2, WR_DATA, RD_WAIT, DISCARD} state_t;

  state_t              state;
  logic                rdst_rdy_n_reg;
  logic                hdr_wr;
  logic                hdr_4dw;
  logic [3:0]          hdr_be;
  logic [15:0]         hdr_req_id;
  logic [7:0]          hdr_tag;
  logic [2:0]          hdr_tc;
  logic [1:0]          hdr_attr;
  logic [ADDR_W-1:0]   hdr_addr;

  logic                beat, sof, eof, dsc;
  logic [7:0]          fmt_type;
  logic                fmt_ok, supported;
  logic [ADDR_W-1:0]   addr_hi_dw;
  logic [ADDR_W-1:0]   addr_lo_dw;
  logic                unused_bits;

  assign beat       = !rx.trn_rsrc_rdy_n && !rdst_rdy_n_reg;
  assign sof        = !rx.trn_rsof_n;
  assign eof        = !rx.trn_reof_n;
  assign dsc        = !rx.trn_rsrc_dsc_n;
  assign fmt_type   = rx.trn_rd[63:56];
  assign fmt_ok     = (fmt_type == 8'h00) || (fmt_type == 8'h20) ||
                      (fmt_type == 8'h40) || (fmt_type == 8'h60);
  // EP poisons writes only; a poisoned read is still answered.
  assign supported  = fmt_ok && (rx.trn_rd[41:32] == 10'd1) && !rx.trn_rbar_hit_n[0] &&
                      !(fmt_type[6] && rx.trn_rd[46]);
  assign addr_hi_dw = rx.trn_rd[ADDR_W+33:34];
  assign addr_lo_dw = rx.trn_rd[ADDR_W+1:2];
  assign unused_bits = ^{rx.trn_rrem_n, rx.trn_rbar_hit_n, rx.trn_rd};

  assign rx.trn_rdst_rdy_n = rdst_rdy_n_reg;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [6:0] lower_addr(input logic [4:0] a, input logic [3:0] be);
    logic [1:0] off;
    casez (be)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return {a, off};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state          <= IDLE;
      rdst_rdy_n_reg <= 1'b1;
      hdr_wr         <= 1'b0;
      hdr_4dw        <= 1'b0;
      hdr_be         <= '0;
      hdr_req_id     <= '0;
      hdr_tag        <= '0;
      hdr_tc         <= '0;
      hdr_attr       <= '0;
      hdr_addr       <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      wr_be          <= '0;
      rd_req_valid   <= 1'b0;
      rd_addr        <= '0;
      rd_req_id      <= '0;
      rd_tag         <= '0;
      rd_tc          <= '0;
      rd_attr        <= '0;
      rd_lower_addr  <= '0;
      rd_be          <= '0;
      drop_cnt       <= '0;
    end else begin
      wr_en <= 1'b0;
      if (rx.trn_lnk_up_n) begin
        state          <= IDLE;
        rd_req_valid   <= 1'b0;
        rdst_rdy_n_reg <= 1'b1;
      end else begin
        rdst_rdy_n_reg <= 1'b0;
        case (state)
          IDLE: if (beat) begin
            if (dsc) begin
              drop_cnt <= sat_inc(drop_cnt);
            end else if (sof && supported && !eof) begin
              state      <= HDR2;
              hdr_wr     <= fmt_type[6];
              hdr_4dw    <= fmt_type[5];
              hdr_tc     <= rx.trn_rd[54:52];
              hdr_attr   <= rx.trn_rd[45:44];
              hdr_req_id <= rx.trn_rd[31:16];
              hdr_tag    <= rx.trn_rd[15:8];
              hdr_be     <= rx.trn_rd[3:0];
            end else if (eof) begin
              drop_cnt <= sat_inc(drop_cnt);
            end else begin
              state <= DISCARD;
            end
          end

          HDR2: if (beat) begin
            if (dsc || (sof && eof) || (hdr_wr && hdr_4dw && eof)) begin
              state    <= IDLE;
              drop_cnt <= sat_inc(drop_cnt);
            end else if (sof || (!eof && !(hdr_wr && hdr_4dw))) begin
              state <= DISCARD;
            end else if (hdr_wr && hdr_4dw) begin
              hdr_addr <= addr_lo_dw;
              state    <= WR_DATA;
            end else if (hdr_wr) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_hi_dw;
              wr_data <= swap32(rx.trn_rd[31:0]);
              wr_be   <= hdr_be;
              state   <= IDLE;
            end else begin
              // Ready drops at this edge so the beat after EOF is never taken.
              state          <= RD_WAIT;
              rdst_rdy_n_reg <= 1'b1;
              rd_req_valid   <= 1'b1;
              rd_addr        <= hdr_4dw ? addr_lo_dw : addr_hi_dw;
              rd_lower_addr  <= lower_addr(hdr_4dw ? rx.trn_rd[6:2] : rx.trn_rd[38:34], hdr_be);
              rd_req_id      <= hdr_req_id;
              rd_tag         <= hdr_tag;
              rd_tc          <= hdr_tc;
              rd_attr        <= hdr_attr;
              rd_be          <= hdr_be;
            end
          end

          WR_DATA: if (beat) begin
            if (dsc || (sof && eof)) begin
              state    <= IDLE;
              drop_cnt <= sat_inc(drop_cnt);
            end else if (sof || !eof) begin
              state <= DISCARD;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= hdr_addr;
              wr_data <= swap32(rx.trn_rd[63:32]);
              wr_be   <= hdr_be;
              state   <= IDLE;
            end
          end

          RD_WAIT: begin
            if (rd_req_ready) begin
              rd_req_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              rdst_rdy_n_reg <= 1'b1;
            end
          end

          DISCARD: if (beat && (eof || dsc)) begin
            state    <= IDLE;
            drop_cnt <= sat_inc(drop_cnt);
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_pio_rx_engine.sv
// Scoreboard bench for pcie_pio_rx_engine: expected writes/reads queued at stimulus time, checked by a monitor.
module tb_pcie_pio_rx_engine;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              trn_reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_req_id;
  logic [7:0]        rd_tag;
  logic [2:0]        rd_tc;
  logic [1:0]        rd_attr;
  logic [6:0]        rd_lower_addr;
  logic [3:0]        rd_be;
  logic [15:0]       drop_cnt;

  pcie_pio_rx_engine_if rx();

  pcie_pio_rx_engine #(.ADDR_W(ADDR_W)) dut (
    .trn_clk      (clk),
    .trn_reset_n  (trn_reset_n),
    .rx           (rx),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_req_id    (rd_req_id),
    .rd_tag       (rd_tag),
    .rd_tc        (rd_tc),
    .rd_attr      (rd_attr),
    .rd_lower_addr(rd_lower_addr),
    .rd_be        (rd_be),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0, beats_acc = 0, acc_in_rd = 0, rd_hi = 0, rdy_viol = 0, stalls = 0;
  logic rd_valid_d = 1'b0;
  logic [15:0] exp_drop = 16'd0;

  logic [45:0] wr_q[$];   // {addr, data, be}
  logic [49:0] rd_q[$];   // {addr, req_id, tag, tc, attr, lower_addr, be}

  function automatic logic [63:0] h0(input logic [7:0] fmt, input logic [9:0] len, input logic ep,
                                     input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] be,
                                     input logic [2:0] tc, input logic [1:0] attr);
    return {fmt, 1'b0, tc, 4'b0, 1'b0, ep, attr, 2'b0, len, rid, tag, 4'b0, be};
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {<<8{d}};
  endfunction

  function automatic logic [6:0] exp_low(input logic [31:0] a, input logic [3:0] be);
    logic [1:0] o;
    o = 2'd0;
    for (int i = 3; i >= 0; i--) if (be[i]) o = i[1:0];
    return {a[6:2], o};
  endfunction

  always @(negedge clk) begin
    logic [45:0] ew;
    logic [49:0] er;
    if (trn_reset_n && !rx.trn_rsrc_rdy_n && !rx.trn_rdst_rdy_n) begin
      beats_acc++;
      if (rd_req_valid) acc_in_rd++;
    end
    if (wr_en) begin
      wr_cnt++;
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got addr=%h data=%h be=%h, required no write", wr_addr, wr_data, wr_be);
      end else begin
        ew = wr_q.pop_front();
        if ({wr_addr, wr_data, wr_be} !== ew) begin
          miscompares++;
          $display("FAIL wr_fields: got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                   wr_addr, wr_data, wr_be, ew[45:36], ew[35:4], ew[3:0]);
        end
      end
      $display("write  addr=%h data=%h be=%h", wr_addr, wr_data, wr_be);
    end
    if (rd_req_valid) begin
      rd_hi++;
      if (!rx.trn_rdst_rdy_n) rdy_viol++;
    end
    if (rd_req_valid && !rd_valid_d) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got addr=%h, required no read request", rd_addr);
      end else begin
        er = rd_q.pop_front();
        if ({rd_addr, rd_req_id, rd_tag, rd_tc, rd_attr, rd_lower_addr, rd_be} !== er) begin
          miscompares++;
          $display("FAIL rd_fields: got %h, required %h",
                   {rd_addr, rd_req_id, rd_tag, rd_tc, rd_attr, rd_lower_addr, rd_be}, er);
        end
      end
      $display("rd_req addr=%h id=%h tag=%h tc=%0d attr=%0d low=%h be=%h",
               rd_addr, rd_req_id, rd_tag, rd_tc, rd_attr, rd_lower_addr, rd_be);
    end
    rd_valid_d = rd_req_valid;
  end

  task automatic idle();
    rx.trn_rsrc_rdy_n = 1'b1;
    rx.trn_rsof_n     = 1'b1;
    rx.trn_reof_n     = 1'b1;
    rx.trn_rsrc_dsc_n = 1'b1;
    rx.trn_rrem_n     = 1'b0;
  endtask

  task automatic send_beat(input logic sof, input logic eof, input logic dsc, input logic rrem,
                           input logic [63:0] d);
    logic taken;
    rx.trn_rsof_n     = !sof;
    rx.trn_reof_n     = !eof;
    rx.trn_rsrc_dsc_n = !dsc;
    rx.trn_rrem_n     = rrem;
    rx.trn_rd         = d;
    rx.trn_rsrc_rdy_n = 1'b0;
    taken = 1'b0;
    for (int n = 0; n < 40 && !taken; n++) begin
      @(negedge clk);
      if (!rx.trn_rdst_rdy_n) taken = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got ready never asserted, required beat accepted within 40 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tlp3(input logic [7:0] fmt, input logic [9:0] len, input logic ep, input logic [6:0] bar,
                      input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] be,
                      input logic [2:0] tc, input logic [1:0] attr, input logic [31:0] addr, input logic [31:0] data);
    rx.trn_rbar_hit_n = bar;
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(fmt, len, ep, rid, tag, be, tc, attr));
    send_beat(1'b0, 1'b1, 1'b0, !fmt[6], {addr, data});
    idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    rx.trn_lnk_up_n = 1'b0;
    rx.trn_rbar_hit_n = 7'h7E;
    rx.trn_rd = '0;
    rd_req_ready = 1'b0;
    idle();
    wait_cycles(3);
    vectors++;
    if ({rx.trn_rdst_rdy_n, wr_en, rd_req_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy_n/wr_en/rd_valid=%b, required 100", {rx.trn_rdst_rdy_n, wr_en, rd_req_valid});
    end
    vectors++;
    if ({drop_cnt, wr_addr, wr_data, wr_be, rd_addr, rd_lower_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: got drop=%h wr_addr=%h wr_data=%h rd_addr=%h, required all 0",
               drop_cnt, wr_addr, wr_data, rd_addr);
    end
    trn_reset_n = 1'b1;
    wait_cycles(1);
    vectors++;
    if (rx.trn_rdst_rdy_n !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got rdst_rdy_n=%b, required 0 in IDLE", rx.trn_rdst_rdy_n);
    end
    $display("reset  done");
  endtask

  task automatic test_mwr32();
    int w0 = wr_cnt;
    wr_q.push_back({10'd4, 32'h44332211, 4'hF});
    tlp3(8'h40, 10'd1, 1'b0, 7'h7E, 16'h0000, 8'h00, 4'hF, 3'd0, 2'd0, 32'h10, 32'h11223344);
    wait_cycles(3);
    vectors++;
    if (wr_cnt - w0 !== 1 || wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mwr32_pulse: got pulses=%0d wr_en=%b, required 1 pulse then 0", wr_cnt - w0, wr_en);
    end
    vectors++;
    if (drop_cnt !== 16'd0 || wr_data !== 32'h44332211) begin
      miscompares++;
      $display("FAIL mwr32_hold: got drop=%0d wr_data=%h, required drop=0 wr_data=44332211", drop_cnt, wr_data);
    end
  endtask

  task automatic test_mwr64();
    int b0 = beats_acc;
    int w0 = wr_cnt;
    wr_q.push_back({10'h3FF, 32'hDDCCBBAA, 4'hF});
    rx.trn_rbar_hit_n = 7'h7E;
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(8'h60, 10'd1, 1'b0, 16'h0000, 8'h01, 4'hF, 3'd0, 2'd0));
    send_beat(1'b0, 1'b0, 1'b0, 1'b0, {32'h0, 32'h0000_0FFC});
    send_beat(1'b0, 1'b1, 1'b0, 1'b1, {32'hAABBCCDD, 32'h0});
    idle();
    wait_cycles(3);
    vectors++;
    if (beats_acc - b0 !== 3 || wr_cnt - w0 !== 1) begin
      miscompares++;
      $display("FAIL mwr64_beats: got beats=%0d writes=%0d, required 3 and 1", beats_acc - b0, wr_cnt - w0);
    end
  endtask

  task automatic test_mrd32_hold();
    int h0c = rd_hi, a0 = acc_in_rd, v0 = rdy_viol;
    rd_q.push_back({10'd9, 16'h0100, 8'h05, 3'd0, 2'd0, 7'h26, 4'b1100});
    rx.trn_rbar_hit_n = 7'h7E;
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(8'h00, 10'd1, 1'b0, 16'h0100, 8'h05, 4'b1100, 3'd0, 2'd0));
    send_beat(1'b0, 1'b1, 1'b0, 1'b1, {32'h24, 32'h0});
    // A stray non-SOF EOF beat stays presented while the request is outstanding.
    rx.trn_rsof_n = 1'b1;
    rx.trn_reof_n = 1'b0;
    rx.trn_rd = 64'hDEAD_BEEF_0000_0000;
    rx.trn_rsrc_rdy_n = 1'b0;
    wait_cycles(5);
    rd_req_ready = 1'b1;
    wait_cycles(1);
    rd_req_ready = 1'b0;
    send_beat(1'b0, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000);
    idle();
    exp_drop = exp_drop + 16'd1;
    wait_cycles(2);
    vectors++;
    if (rd_hi - h0c !== 6) begin
      miscompares++;
      $display("FAIL mrd_valid_len: got %0d cycles, required 6", rd_hi - h0c);
    end
    vectors++;
    if (acc_in_rd - a0 !== 0 || rdy_viol - v0 !== 0) begin
      miscompares++;
      $display("FAIL mrd_ready_hold: got beats_in_wait=%0d ready_low=%0d, required 0 and 0",
               acc_in_rd - a0, rdy_viol - v0);
    end
    vectors++;
    if (drop_cnt !== exp_drop) begin
      miscompares++;
      $display("FAIL mrd_stray_drop: got drop=%0d, required %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_unsupported();
    int w0 = wr_cnt;
    tlp3(8'h40, 10'd2, 1'b0, 7'h7E, 16'h0, 8'h10, 4'hF, 3'd0, 2'd0, 32'h20, 32'h01020304);
    tlp3(8'h40, 10'd1, 1'b0, 7'h7D, 16'h0, 8'h11, 4'hF, 3'd0, 2'd0, 32'h20, 32'h05060708);
    exp_drop = exp_drop + 16'd2;
    wait_cycles(2);
    vectors++;
    if (drop_cnt !== exp_drop || wr_cnt - w0 !== 0) begin
      miscompares++;
      $display("FAIL unsup_writes: got drop=%0d writes=%0d, required drop=%0d writes=0", drop_cnt, wr_cnt - w0, exp_drop);
    end
    rd_q.push_back({10'd2, 16'hABCD, 8'h12, 3'd0, 2'd0, exp_low(32'h8, 4'b0110), 4'b0110});
    tlp3(8'h00, 10'd1, 1'b1, 7'h7E, 16'hABCD, 8'h12, 4'b0110, 3'd0, 2'd0, 32'h8, 32'h0);
    rd_req_ready = 1'b1;
    wait_cycles(1);
    rd_req_ready = 1'b0;
    wait_cycles(1);
    vectors++;
    if (drop_cnt !== exp_drop || rd_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ep_read: got drop=%0d rd_valid=%b, required drop=%0d rd_valid=0", drop_cnt, rd_req_valid, exp_drop);
    end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt;
    rx.trn_rbar_hit_n = 7'h7E;
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(8'h60, 10'd1, 1'b0, 16'h0, 8'h20, 4'hF, 3'd0, 2'd0));
    send_beat(1'b0, 1'b0, 1'b1, 1'b0, {32'h0, 32'h40});
    idle();
    exp_drop = exp_drop + 16'd1;
    wait_cycles(2);
    vectors++;
    if (drop_cnt !== exp_drop || wr_cnt - w0 !== 0) begin
      miscompares++;
      $display("FAIL abort: got drop=%0d writes=%0d, required drop=%0d writes=0", drop_cnt, wr_cnt - w0, exp_drop);
    end
    wr_q.push_back({10'h0C, bswap(32'hCAFEF00D), 4'b0011});
    tlp3(8'h40, 10'd1, 1'b0, 7'h7E, 16'h0, 8'h21, 4'b0011, 3'd0, 2'd0, 32'h30, 32'hCAFEF00D);
    wait_cycles(2);
    vectors++;
    if (wr_cnt - w0 !== 1 || drop_cnt !== exp_drop) begin
      miscompares++;
      $display("FAIL abort_recover: got writes=%0d drop=%0d, required 1 and %0d", wr_cnt - w0, drop_cnt, exp_drop);
    end
  endtask

  task automatic test_link_down();
    int w0;
    rd_q.push_back({10'h0F, 16'h0203, 8'h33, 3'd5, 2'd2, exp_low(32'h3C, 4'b0001), 4'b0001});
    tlp3(8'h00, 10'd1, 1'b0, 7'h7E, 16'h0203, 8'h33, 4'b0001, 3'd5, 2'd2, 32'h3C, 32'h0);
    rx.trn_lnk_up_n = 1'b1;
    wait_cycles(1);
    vectors++;
    if (rd_req_valid !== 1'b0 || rx.trn_rdst_rdy_n !== 1'b1) begin
      miscompares++;
      $display("FAIL link_down: got rd_valid=%b rdy_n=%b, required 0 and 1", rd_req_valid, rx.trn_rdst_rdy_n);
    end
    wait_cycles(3);
    vectors++;
    if (rx.trn_rdst_rdy_n !== 1'b1 || drop_cnt !== exp_drop || rd_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL link_hold: got rdy_n=%b drop=%0d rd_valid=%b, required 1 %0d 0",
               rx.trn_rdst_rdy_n, drop_cnt, rd_req_valid, exp_drop);
    end
    rx.trn_lnk_up_n = 1'b0;
    wait_cycles(1);
    vectors++;
    if (rx.trn_rdst_rdy_n !== 1'b0) begin
      miscompares++;
      $display("FAIL link_up_ready: got rdy_n=%b, required 0", rx.trn_rdst_rdy_n);
    end
    w0 = wr_cnt;
    wr_q.push_back({10'h001, bswap(32'h0BADF00D), 4'hF});
    tlp3(8'h40, 10'd1, 1'b0, 7'h7E, 16'h0, 8'h34, 4'hF, 3'd0, 2'd0, 32'h4, 32'h0BADF00D);
    wait_cycles(2);
    vectors++;
    if (wr_cnt - w0 !== 1) begin
      miscompares++;
      $display("FAIL link_idle: got writes=%0d, required 1", wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt;
    int s0;
    logic [31:0] d;
    rx.trn_rbar_hit_n = 7'h7E;
    send_beat(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);  // prime: stray non-SOF starts a discard
    send_beat(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    exp_drop = exp_drop + 16'd1;
    s0 = stalls;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wr_q.push_back({10'h40 + 10'(i), bswap(d), 4'hF});
      send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(8'h40, 10'd1, 1'b0, 16'h0, 8'(i), 4'hF, 3'd0, 2'd0));
      send_beat(1'b0, 1'b1, 1'b0, 1'b0, {32'h100 + 32'(4 * i), d});
    end
    idle();
    wait_cycles(3);
    vectors++;
    if (stalls - s0 !== 0 || wr_cnt - w0 !== 4) begin
      miscompares++;
      $display("FAIL back_to_back: got stalls=%0d writes=%0d, required 0 and 4", stalls - s0, wr_cnt - w0);
    end
    vectors++;
    if (drop_cnt !== exp_drop) begin
      miscompares++;
      $display("FAIL b2b_drop: got drop=%0d, required %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    rx.trn_rbar_hit_n = 7'h7E;
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, h0(8'h60, 10'd1, 1'b0, 16'h0, 8'h50, 4'hF, 3'd0, 2'd0));
    trn_reset_n = 1'b0;
    #2;
    vectors++;
    if (rx.trn_rdst_rdy_n !== 1'b1 || drop_cnt !== 16'd0 || wr_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got rdy_n=%b drop=%0d wr_addr=%h, required 1 0 0",
               rx.trn_rdst_rdy_n, drop_cnt, wr_addr);
    end
    @(posedge clk); #1;
    trn_reset_n = 1'b1;
    exp_drop = 16'd0;
    send_beat(1'b0, 1'b0, 1'b0, 1'b0, {32'h0, 32'h40});
    send_beat(1'b0, 1'b1, 1'b0, 1'b1, {32'h12345678, 32'h0});
    idle();
    exp_drop = exp_drop + 16'd1;
    wait_cycles(3);
    vectors++;
    if (drop_cnt !== exp_drop || wr_cnt - w0 !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_tail: got drop=%0d writes=%0d, required %0d and 0", drop_cnt, wr_cnt - w0, exp_drop);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mwr32();
    test_mwr64();
    test_mrd32_hold();
    test_unsupported();
    test_abort();
    test_link_down();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left: got %0d writes %0d reads pending, required 0", wr_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
